lpm_mem_arbiter: RTL and testbench

- Shares the single LPM lookup memory between two requesters: the new-lookup path (port E, "enter") and the recirculation path (port R, "recirc").
- Issues at most one memory request per cycle and tracks the owner of every outstanding request in an in-order tag queue, so each memory response is routed back to the requester that issued it.
- Sits between the LPM pipeline rules and the lookup memory, replacing the direct rule-to-memory connection.

---
 rtl/lpm_pkg.sv | 16 +
 rtl/lpm_mem_arbiter_if.sv | 48 ++++
 rtl/lpm_tag_fifo.sv | 52 +++++
 rtl/lpm_mem_arbiter.sv | 82 ++++++++
 tb/tb_lpm_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lpm_pkg.sv
// Shared definitions for the LPM memory arbiter: requester IDs and default widths.
package lpm_pkg;

    // Owner ID stored in the tag queue for every in-flight memory request.
    localparam logic OWN_E = 1'b0;  // new-lookup (enter) path
    localparam logic OWN_R = 1'b1;  // recirculation path

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Width of an occupancy counter that must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lpm_mem_arbiter_if.sv
// Bus bundle between the LPM rules, the arbiter and the lookup memory.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface lpm_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // enter (E) request / response
    logic              enter_req_ena;
    logic [ADDR_W-1:0] enter_req_v;
    logic              enter_req_rdy;
    logic              enter_res_ena;
    logic [DATA_W-1:0] enter_res_v;
    logic              enter_res_rdy;
    // recirc (R) request / response
    logic              recirc_req_ena;
    logic [ADDR_W-1:0] recirc_req_v;
    logic              recirc_req_rdy;
    logic              recirc_res_ena;
    logic [DATA_W-1:0] recirc_res_v;
    logic              recirc_res_rdy;
    // lookup memory
    logic              mem_req_ena;
    logic [ADDR_W-1:0] mem_req_v;
    logic              mem_req_rdy;
    logic [DATA_W-1:0] mem_res_value;
    logic              mem_res_value_rdy;
    logic              mem_res_accept_ena;
    // status
    logic              busy;

    modport slave (
        input  enter_req_ena, enter_req_v, enter_res_rdy,
        input  recirc_req_ena, recirc_req_v, recirc_res_rdy,
        input  mem_req_rdy, mem_res_value, mem_res_value_rdy,
        output enter_req_rdy, enter_res_ena, enter_res_v,
        output recirc_req_rdy, recirc_res_ena, recirc_res_v,
        output mem_req_ena, mem_req_v, mem_res_accept_ena, busy
    );

    modport master (
        output enter_req_ena, enter_req_v, enter_res_rdy,
        output recirc_req_ena, recirc_req_v, recirc_res_rdy,
        output mem_req_rdy, mem_res_value, mem_res_value_rdy,
        input  enter_req_rdy, enter_res_ena, enter_res_v,
        input  recirc_req_rdy, recirc_res_ena, recirc_res_v,
        input  mem_req_ena, mem_req_v, mem_res_accept_ena, busy
    );
endinterface

// File: rtl/lpm_tag_fifo.sv
// In-order queue of 1-bit owner tags for outstanding memory requests.
// A push while full is legal when a pop happens in the same cycle (bypass):
// the slot being written is the one whose head is retiring.
module lpm_tag_fifo
    import lpm_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_tag,
    input  logic             pop,
    output logic             head,
    output logic [CNT_W-1:0] count
);
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             tags_reg [DEPTH];

    // Tag storage: one flop per slot, written when the write pointer selects it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (push && wr_ptr_reg == PTR_W'(gi)) begin
                tags_reg[gi] <= push_tag;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = tags_reg[rd_ptr_reg];
    assign count = count_reg;
endmodule

// File: rtl/lpm_mem_arbiter.sv
// Shares the LPM lookup memory between the enter and recirc paths: one request
// per cycle, recirc-first with a starvation override, and in-order routing of
// responses back to their issuer via the tag queue.
module lpm_mem_arbiter
    import lpm_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_OUT      = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic               clk,
    input logic               rst,
    lpm_mem_arbiter_if.slave  bus
);
    localparam int CNT_W = cnt_width(MAX_OUT);

    logic [CNT_W-1:0] tag_count;
    logic             head;
    logic             empty;
    logic             full;
    logic             e_res_ena;
    logic             r_res_ena;
    logic             retire;
    logic             can_issue;
    logic             force_e;
    logic             e_grant;
    logic             r_grant;
    logic [7:0]       starve_cnt_reg;

    assign empty = (tag_count == '0);
    assign full  = (tag_count == CNT_W'(MAX_OUT));

    // Response routing: only the queue head may retire, so a stalled owner
    // blocks every later response. Responses with nothing outstanding are ignored.
    assign e_res_ena = bus.mem_res_value_rdy & !empty & (head == OWN_E);
    assign r_res_ena = bus.mem_res_value_rdy & !empty & (head == OWN_R);
    assign retire    = (e_res_ena & bus.enter_res_rdy) | (r_res_ena & bus.recirc_res_rdy);

    // Issue is gated by reset so the ready outputs drop the moment rst rises.
    assign can_issue = !rst & bus.mem_req_rdy & (!full | retire);
    assign force_e   = (starve_cnt_reg == 8'(STARVE_LIMIT));

    assign bus.recirc_req_rdy = can_issue & !(force_e & bus.enter_req_ena);
    assign bus.enter_req_rdy  = can_issue & (!bus.recirc_req_ena | force_e);
    assign e_grant = bus.enter_req_ena  & bus.enter_req_rdy;
    assign r_grant = bus.recirc_req_ena & bus.recirc_req_rdy;

    assign bus.mem_req_ena = e_grant | r_grant;
    assign bus.mem_req_v   = e_grant ? bus.enter_req_v :
                             r_grant ? bus.recirc_req_v : '0;

    assign bus.enter_res_ena      = e_res_ena;
    assign bus.recirc_res_ena     = r_res_ena;
    assign bus.enter_res_v        = e_res_ena ? bus.mem_res_value : '0;
    assign bus.recirc_res_v       = r_res_ena ? bus.mem_res_value : '0;
    assign bus.mem_res_accept_ena = retire;
    assign bus.busy               = !empty;

    // Starvation counter: counts R wins over a waiting E, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else if (e_grant || !bus.enter_req_ena) begin
            starve_cnt_reg <= '0;
        end else if (r_grant && !force_e) begin
            starve_cnt_reg <= starve_cnt_reg + 8'd1;
        end
    end

    lpm_tag_fifo #(
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.mem_req_ena),
        .push_tag (r_grant ? OWN_R : OWN_E),
        .pop      (retire),
        .head     (head),
        .count    (tag_count)
    );
endmodule

// File: tb/tb_lpm_mem_arbiter.sv
// Directed self-checking bench for lpm_mem_arbiter (MAX_OUT=4, STARVE_LIMIT=8).
module tb_lpm_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lpm_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lpm_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUT(4), .STARVE_LIMIT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle_inputs();
        bus.enter_req_ena     = 1'b0;
        bus.enter_req_v       = '0;
        bus.recirc_req_ena    = 1'b0;
        bus.recirc_req_v      = '0;
        bus.enter_res_rdy     = 1'b0;
        bus.recirc_res_rdy    = 1'b0;
        bus.mem_req_rdy       = 1'b1;
        bus.mem_res_value     = '0;
        bus.mem_res_value_rdy = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.enter_req_ena = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.enter_req_rdy !== 1'b0) begin errors++; $display("FAIL reset_e_rdy got %b want 0", bus.enter_req_rdy); end
        checks++; if (bus.mem_req_ena !== 1'b0) begin errors++; $display("FAIL reset_mem_ena got %b want 0", bus.mem_req_ena); end
        $display("reset: busy=%b e_rdy=%b mem_ena=%b", bus.busy, bus.enter_req_rdy, bus.mem_req_ena);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.enter_req_ena = 1'b1; bus.enter_req_v = 32'h0000_1234;
        #1;
        checks++; if (bus.mem_req_ena !== 1'b1 || bus.mem_req_v !== 32'h1234) begin errors++; $display("FAIL single_issue got ena=%b v=%h want 1 00001234", bus.mem_req_ena, bus.mem_req_v); end
        $display("single: issue ena=%b v=%h", bus.mem_req_ena, bus.mem_req_v);
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.mem_req_ena !== 1'b0 || bus.mem_req_v !== 32'h0) begin errors++; $display("FAIL single_idle_req got ena=%b v=%h want 0 0", bus.mem_req_ena, bus.mem_req_v); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bus.busy); end
        @(negedge clk); @(negedge clk);
        bus.mem_res_value_rdy = 1'b1; bus.mem_res_value = 32'h55; bus.enter_res_rdy = 1'b1;
        #1;
        checks++; if (bus.enter_res_ena !== 1'b1 || bus.enter_res_v !== 32'h55) begin errors++; $display("FAIL single_res_e got ena=%b v=%h want 1 00000055", bus.enter_res_ena, bus.enter_res_v); end
        checks++; if (bus.recirc_res_ena !== 1'b0 || bus.recirc_res_v !== 32'h0) begin errors++; $display("FAIL single_res_r got ena=%b v=%h want 0 0", bus.recirc_res_ena, bus.recirc_res_v); end
        checks++; if (bus.mem_res_accept_ena !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", bus.mem_res_accept_ena); end
        $display("single: response e_ena=%b v=%h", bus.enter_res_ena, bus.enter_res_v);
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_done_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_starve();
        @(negedge clk);
        bus.enter_req_ena  = 1'b1; bus.enter_req_v  = 32'hE0;
        bus.recirc_req_ena = 1'b1; bus.recirc_req_v = 32'hA0;
        bus.mem_res_value_rdy = 1'b1; bus.mem_res_value = 32'h99;
        bus.enter_res_rdy = 1'b1; bus.recirc_res_rdy = 1'b1;
        for (int i = 0; i < 27; i++) begin
            logic       exp_r;
            logic [31:0] exp_v;
            exp_r = ((i % 9) != 8);
            exp_v = exp_r ? 32'hA0 : 32'hE0;
            #1;
            checks++;
            if (bus.mem_req_v !== exp_v || bus.recirc_req_rdy !== exp_r || bus.enter_req_rdy !== !exp_r) begin
                errors++;
                $display("FAIL starve_grant[%0d] got v=%h r_rdy=%b e_rdy=%b want v=%h r_rdy=%b e_rdy=%b",
                         i, bus.mem_req_v, bus.recirc_req_rdy, bus.enter_req_rdy, exp_v, exp_r, !exp_r);
            end
            $display("starve: cycle %0d grant v=%h", i, bus.mem_req_v);
            @(negedge clk);
        end
        bus.enter_req_ena = 1'b0; bus.recirc_req_ena = 1'b0;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL starve_drain_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_full_bypass();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.enter_req_ena = 1'b1; bus.enter_req_v = 32'h100 + i;
            #1;
            checks++; if (bus.enter_req_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy[%0d] got %b want 1", i, bus.enter_req_rdy); end
            $display("full: fill %0d rdy=%b", i, bus.enter_req_rdy);
            @(negedge clk);
        end
        bus.enter_req_v = 32'h104;
        #1;
        checks++; if (bus.enter_req_rdy !== 1'b0 || bus.mem_req_ena !== 1'b0) begin errors++; $display("FAIL full_block got rdy=%b ena=%b want 0 0", bus.enter_req_rdy, bus.mem_req_ena); end
        bus.mem_res_value_rdy = 1'b1; bus.mem_res_value = 32'h77; bus.enter_res_rdy = 1'b1;
        #1;
        checks++; if (bus.mem_res_accept_ena !== 1'b1 || bus.enter_req_rdy !== 1'b1 || bus.mem_req_v !== 32'h104) begin
            errors++; $display("FAIL full_bypass got acc=%b rdy=%b v=%h want 1 1 00000104", bus.mem_res_accept_ena, bus.enter_req_rdy, bus.mem_req_v);
        end
        $display("full: bypass acc=%b rdy=%b v=%h", bus.mem_res_accept_ena, bus.enter_req_rdy, bus.mem_req_v);
        @(negedge clk);
        bus.mem_res_value_rdy = 1'b0;
        #1;
        checks++; if (bus.enter_req_rdy !== 1'b0) begin errors++; $display("FAIL still_full got rdy=%b want 0", bus.enter_req_rdy); end
        bus.enter_req_ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_res_value_rdy = 1'b1;
            #1;
            checks++; if (bus.mem_res_accept_ena !== 1'b1) begin errors++; $display("FAIL drain_acc[%0d] got %b want 1", i, bus.mem_res_accept_ena); end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL full_drain_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_order_stall();
        @(negedge clk);
        bus.enter_req_ena = 1'b1; bus.enter_req_v = 32'h10;
        @(negedge clk);
        bus.enter_req_ena = 1'b0; bus.recirc_req_ena = 1'b1; bus.recirc_req_v = 32'h20;
        #1;
        checks++; if (bus.recirc_req_rdy !== 1'b1 || bus.mem_req_v !== 32'h20) begin errors++; $display("FAIL order_r_issue got rdy=%b v=%h want 1 00000020", bus.recirc_req_rdy, bus.mem_req_v); end
        @(negedge clk);
        bus.recirc_req_ena = 1'b0; bus.enter_req_ena = 1'b1; bus.enter_req_v = 32'h30;
        @(negedge clk);
        idle_inputs();
        bus.mem_res_value_rdy = 1'b1; bus.mem_res_value = 32'hA; bus.enter_res_rdy = 1'b1;
        #1;
        checks++; if (bus.enter_res_ena !== 1'b1 || bus.enter_res_v !== 32'hA || bus.mem_res_accept_ena !== 1'b1) begin
            errors++; $display("FAIL order_a got ena=%b v=%h acc=%b want 1 0000000a 1", bus.enter_res_ena, bus.enter_res_v, bus.mem_res_accept_ena);
        end
        $display("order: 0xA to E ena=%b", bus.enter_res_ena);
        @(negedge clk);
        bus.mem_res_value = 32'hB;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.recirc_res_ena !== 1'b1 || bus.mem_res_accept_ena !== 1'b0 || bus.enter_res_ena !== 1'b0) begin
                errors++; $display("FAIL order_stall[%0d] got r_ena=%b acc=%b e_ena=%b want 1 0 0", i, bus.recirc_res_ena, bus.mem_res_accept_ena, bus.enter_res_ena);
            end
            $display("order: stall %0d acc=%b", i, bus.mem_res_accept_ena);
            @(negedge clk);
        end
        bus.recirc_res_rdy = 1'b1;
        #1;
        checks++; if (bus.recirc_res_v !== 32'hB || bus.mem_res_accept_ena !== 1'b1) begin errors++; $display("FAIL order_b got v=%h acc=%b want 0000000b 1", bus.recirc_res_v, bus.mem_res_accept_ena); end
        @(negedge clk);
        bus.mem_res_value = 32'hC;
        #1;
        checks++; if (bus.enter_res_ena !== 1'b1 || bus.enter_res_v !== 32'hC || bus.recirc_res_ena !== 1'b0) begin
            errors++; $display("FAIL order_c got e_ena=%b v=%h r_ena=%b want 1 0000000c 0", bus.enter_res_ena, bus.enter_res_v, bus.recirc_res_ena);
        end
        $display("order: 0xC to E v=%h", bus.enter_res_v);
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL order_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.enter_req_ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.enter_req_v = 32'h200 + i;
            @(negedge clk);
        end
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", bus.busy); end
        bus.recirc_req_ena = 1'b1; bus.mem_res_value_rdy = 1'b1;
        bus.enter_res_rdy = 1'b1; bus.recirc_res_rdy = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.enter_req_rdy !== 1'b0 || bus.recirc_req_rdy !== 1'b0 || bus.mem_req_ena !== 1'b0 ||
            bus.enter_res_ena !== 1'b0 || bus.recirc_res_ena !== 1'b0 || bus.mem_res_accept_ena !== 1'b0 || bus.mem_req_v !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs got busy=%b erdy=%b rrdy=%b mena=%b eres=%b rres=%b acc=%b v=%h want all 0",
                     bus.busy, bus.enter_req_rdy, bus.recirc_req_rdy, bus.mem_req_ena,
                     bus.enter_res_ena, bus.recirc_res_ena, bus.mem_res_accept_ena, bus.mem_req_v);
        end
        $display("reset_mid: busy=%b mem_ena=%b", bus.busy, bus.mem_req_ena);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        bus.enter_req_ena = 1'b1; bus.enter_req_v = 32'h500;
        #1;
        checks++; if (bus.mem_req_ena !== 1'b1 || bus.mem_req_v !== 32'h500) begin errors++; $display("FAIL mid_new_issue got ena=%b v=%h want 1 00000500", bus.mem_req_ena, bus.mem_req_v); end
        @(negedge clk);
        idle_inputs();
        bus.mem_res_value_rdy = 1'b1; bus.mem_res_value = 32'h5A; bus.enter_res_rdy = 1'b1;
        #1;
        checks++; if (bus.mem_res_accept_ena !== 1'b1) begin errors++; $display("FAIL mid_retire got %b want 1", bus.mem_res_accept_ena); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_count_one got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_idle_response();
        @(negedge clk);
        bus.mem_res_value_rdy = 1'b1; bus.mem_res_value = 32'hDEAD;
        bus.enter_res_rdy = 1'b1; bus.recirc_res_rdy = 1'b1;
        #1;
        checks++; if (bus.enter_res_ena !== 1'b0 || bus.recirc_res_ena !== 1'b0 || bus.mem_res_accept_ena !== 1'b0) begin
            errors++; $display("FAIL idle_response got e=%b r=%b acc=%b want 0 0 0", bus.enter_res_ena, bus.recirc_res_ena, bus.mem_res_accept_ena);
        end
        checks++; if (bus.enter_res_v !== 32'h0 || bus.recirc_res_v !== 32'h0) begin errors++; $display("FAIL idle_res_v got %h %h want 0 0", bus.enter_res_v, bus.recirc_res_v); end
        $display("idle_response: acc=%b", bus.mem_res_accept_ena);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_starve();
        test_full_bypass();
        test_order_stall();
        test_reset_mid();
        test_idle_response();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without finishing");
        $fatal(1);
    end
endmodule
